// File: rtl/cv32e40p_ex_mdu_stage.sv
// cv32e40p_ex_mdu_stage: multi-cycle M-extension unit sitting beside the EX ALU.
// The multiplier is shift-add, retiring MUL_UNROLL multiplier bits per cycle.
// The divider is restoring and produces one quotient bit per cycle. Both work on
// operand magnitudes, and FIX applies the result signs.
// Build option: define CV32E40P_MDU_DIV_EN to include the divider. Without it,
// div ops complete in one step with a zero result and the destination forwarded.
//
// state | meaning
// IDLE  | waiting for an op, op_ready_o high
// MUL   | shift-add iterations on |a|,|b|
// DIV   | restoring divide iterations (CV32E40P_MDU_DIV_EN only)
// FIX   | sign correction and half select into wb_wdata_o
// DONE  | result presented to WB until the valid/ready handshake
module cv32e40p_ex_mdu_stage #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 5,
  parameter int MUL_UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   operand_a_i,
  input  logic [XLEN-1:0]   operand_b_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [ADDR_W-1:0] wb_waddr_o,
  output logic [XLEN-1:0]   wb_wdata_o
);

  localparam int N_MUL = XLEN / MUL_UNROLL;
  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
`ifdef CV32E40P_MDU_DIV_EN
    S_DIV,
`endif
    S_FIX,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          op_q;
  logic                neg_q;
  logic [2*XLEN-1:0]   acc_q, mcand_q, mul_sum, mul_res;
  logic [XLEN-1:0]     mplier_q;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic                accept, is_div, hs, last_step;
  logic                a_signed, b_signed, a_neg, b_neg;

`ifdef CV32E40P_MDU_DIV_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic                div_q, a_neg_q;
  logic [XLEN-1:0]     rem_q, rem_nxt, quo_res, rem_res;
  logic [XLEN:0]       rem_sh;
  logic                q_bit, div_zero, div_ovf;
`endif

  assign op_ready_o = (state_q == S_IDLE);
  assign busy_o     = (state_q != S_IDLE);
  assign accept     = op_valid_i & op_ready_o & ~flush_i;
  assign hs         = wb_valid_o & wb_ready_i;
  assign is_div     = op_i[2];
  // MUL/MULH/MULHSU treat rs1 as signed, MUL/MULH rs2; DIV/REM both
  assign a_signed   = is_div ? ~op_i[0] : (op_i[1:0] != 2'd3);
  assign b_signed   = is_div ? ~op_i[0] : ~op_i[1];
  assign a_neg      = a_signed & operand_a_i[XLEN-1];
  assign b_neg      = b_signed & operand_b_i[XLEN-1];
  // magnitude of -2^(XLEN-1) is 2^(XLEN-1), which still fits unsigned XLEN bits
  assign mag_a      = a_neg ? -operand_a_i : operand_a_i;
  assign mag_b      = b_neg ? -operand_b_i : operand_b_i;

`ifdef CV32E40P_MDU_DIV_EN
  assign div_zero = (operand_b_i == '0);
  assign div_ovf  = ~op_i[0] & (operand_a_i == INT_MIN) & (&operand_b_i);

  // one restoring step: shift next dividend bit into the partial remainder
  always_comb begin
    rem_sh  = {rem_q, mplier_q[XLEN-1]};
    q_bit   = (rem_sh >= {1'b0, mcand_q[XLEN-1:0]});
    rem_nxt = rem_sh[XLEN-1:0];
    if (q_bit) rem_nxt = XLEN'(rem_sh - {1'b0, mcand_q[XLEN-1:0]});
  end

  assign quo_res = neg_q   ? -mplier_q : mplier_q;
  assign rem_res = a_neg_q ? -rem_q    : rem_q;
`endif

  // add MUL_UNROLL shifted partial products for the current multiplier slice
  always_comb begin
    mul_sum = acc_q;
    for (int j = 0; j < MUL_UNROLL; j++) begin
      if (mplier_q[j]) mul_sum = mul_sum + (mcand_q << j);
    end
  end

  assign mul_res = neg_q ? -acc_q : acc_q;

  // terminal count of the active iteration phase
  always_comb begin
    last_step = 1'b0;
    if (state_q == S_MUL) last_step = (cnt_q == CNT_W'(N_MUL - 1));
`ifdef CV32E40P_MDU_DIV_EN
    if (state_q == S_DIV) last_step = (cnt_q == CNT_W'(XLEN - 1));
`endif
  end

  // next-state logic; flush overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_div) state_d = S_MUL;
`ifdef CV32E40P_MDU_DIV_EN
          else if (div_zero || div_ovf) state_d = S_DONE;
          else state_d = S_DIV;
`else
          else state_d = S_DONE;
`endif
        end
      end
      S_MUL:  if (last_step) state_d = S_FIX;
`ifdef CV32E40P_MDU_DIV_EN
      S_DIV:  if (last_step) state_d = S_FIX;
`endif
      S_FIX:  state_d = S_DONE;
      S_DONE: if (hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // state register; wb_valid_o trails entry into DONE by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wb_valid_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_o <= (state_q == S_DONE) & ~hs & ~flush_i;
    end
  end

  // operand latch, iteration datapath and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      op_q       <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      wb_waddr_o <= '0;
      wb_wdata_o <= '0;
`ifdef CV32E40P_MDU_DIV_EN
      div_q      <= 1'b0;
      a_neg_q    <= 1'b0;
      rem_q      <= '0;
`endif
    end else if (accept) begin
      cnt_q      <= '0;
      op_q       <= op_i[1:0];
      neg_q      <= a_neg ^ b_neg;
      acc_q      <= '0;
      mcand_q    <= {{XLEN{1'b0}}, (is_div ? mag_b : mag_a)};
      mplier_q   <= is_div ? mag_a : mag_b;
      wb_waddr_o <= waddr_i;
`ifdef CV32E40P_MDU_DIV_EN
      div_q      <= is_div;
      a_neg_q    <= a_neg;
      rem_q      <= '0;
      if (is_div && div_zero)     wb_wdata_o <= op_i[1] ? operand_a_i : '1;
      else if (is_div && div_ovf) wb_wdata_o <= op_i[1] ? '0 : operand_a_i;
`else
      if (is_div) wb_wdata_o <= '0;
`endif
    end else begin
      case (state_q)
        S_MUL: begin
          cnt_q    <= cnt_q + 1'b1;
          acc_q    <= mul_sum;
          mcand_q  <= mcand_q << MUL_UNROLL;
          mplier_q <= mplier_q >> MUL_UNROLL;
        end
`ifdef CV32E40P_MDU_DIV_EN
        S_DIV: begin
          cnt_q    <= cnt_q + 1'b1;
          rem_q    <= rem_nxt;
          mplier_q <= {mplier_q[XLEN-2:0], q_bit};
        end
`endif
        S_FIX: begin
`ifdef CV32E40P_MDU_DIV_EN
          if (div_q) wb_wdata_o <= op_q[1] ? rem_res : quo_res;
          else
`endif
          wb_wdata_o <= (op_q == 2'd0) ? mul_res[XLEN-1:0] : mul_res[2*XLEN-1:XLEN];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_ex_mdu_stage.sv
// Self-checking bench for cv32e40p_ex_mdu_stage: directed corner cases plus
// random ops compared against a plain-arithmetic reference model.
module tb_cv32e40p_ex_mdu_stage;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int UNROLL = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              op_valid_i, op_ready_o, flush_i, busy_o;
  logic              wb_valid_o, wb_ready_i;
  logic [2:0]        op_i;
  logic [XLEN-1:0]   operand_a_i, operand_b_i, wb_wdata_o;
  logic [ADDR_W-1:0] waddr_i, wb_waddr_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cv32e40p_ex_mdu_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MUL_UNROLL(UNROLL)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_i(op_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .waddr_i(waddr_i),
    .flush_i(flush_i), .busy_o(busy_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_waddr_o(wb_waddr_o), .wb_wdata_o(wb_wdata_o)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference result from the ISA definition using 64-bit arithmetic
  function automatic logic [31:0] ref_data(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    ea = (op != 3'd3 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    eb = (op <= 3'd1 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p  = ea * eb;
    if (op == 3'd0) return p[31:0];
    if (op < 3'd4)  return p[63:32];
`ifdef CV32E40P_MDU_DIV_EN
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    sa = a;
    sb = b;
    if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    return op[1] ? a % b : a / b;
`else
    sa = 0;
    sb = 0;
    return 32'(sa + sb);
`endif
  endfunction

  // edges from accept until wb_valid_o is seen high
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return XLEN / UNROLL + 2;
`ifdef CV32E40P_MDU_DIV_EN
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
`else
    if (a == b) return 1;
    return 1;
`endif
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input int hold);
    int lat;
    logic [31:0] exp_d;
    int exp_l;
    exp_d = ref_data(op, a, b);
    exp_l = ref_lat(op, a, b);
    @(negedge clk);
    op_valid_i  = 1'b1;
    op_i        = op;
    operand_a_i = a;
    operand_b_i = b;
    waddr_i     = wa;
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    check_val("busy_after_accept", busy_o, 1);
    lat = 0;
    while (lat < 80) begin
      @(posedge clk); #1;
      lat++;
      if (wb_valid_o) break;
    end
    check_val("latency", lat, exp_l);
    check_val("wdata", wb_wdata_o, exp_d);
    check_val("waddr", wb_waddr_o, wa);
    if (hold > 0) begin
      // a new op offered while the result waits must not be taken
      op_valid_i = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        check_val("hold_valid", wb_valid_o, 1);
        check_val("hold_wdata", wb_wdata_o, exp_d);
        check_val("hold_waddr", wb_waddr_o, wa);
        check_val("hold_op_ready", op_ready_o, 0);
      end
    end
    wb_ready_i = 1'b1;
    @(posedge clk); #1;
    wb_ready_i = 1'b0;
    check_val("valid_drop", wb_valid_o, 0);
    check_val("ready_after_hs", op_ready_o, 1);
    check_val("no_accept_at_hs", busy_o, 0);
    op_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    int sel;
    rst_n = 1'b0; op_valid_i = 1'b0; op_i = '0; operand_a_i = '0; operand_b_i = '0;
    waddr_i = '0; flush_i = 1'b0; wb_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_wb_valid", wb_valid_o, 0);
    check_val("rst_wdata", wb_wdata_o, 0);
    check_val("rst_waddr", wb_waddr_o, 0);
    check_val("rst_op_ready", op_ready_o, 1);
    check_val("rst_busy", busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd6,  0);
    run_op(3'd4, -32'sd7,       32'd2,         5'd7,  0);
    run_op(3'd6, -32'sd7,       32'd2,         5'd8,  0);
    run_op(3'd5, 32'd5,         32'd0,         5'd9,  0);
    run_op(3'd7, 32'd5,         32'd0,         5'd10, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    run_op(3'd4, 32'd100,       32'd7,         5'd13, 0);
    run_op(3'd0, 32'd3,         32'd4,         5'd14, 5);
    run_op(3'd7, 32'd100,       32'd7,         5'd15, 5);

    // flush in the middle of a multiply
    @(negedge clk);
    op_valid_i = 1'b1; op_i = 3'd0; operand_a_i = 32'd9; operand_b_i = 32'd9; waddr_i = 5'd1;
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check_val("flush_busy", busy_o, 0);
    check_val("flush_op_ready", op_ready_o, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (wb_valid_o) seen = 1'b1;
    end
    check_val("flush_no_valid", seen, 0);

    // flush beats a simultaneous op_valid
    @(negedge clk);
    op_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    op_valid_i = 1'b0; flush_i = 1'b0;
    check_val("flush_blocks_accept", busy_o, 0);

    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = $urandom;
      sel  = $urandom_range(0, 7);
      if (sel == 0) r_b = 32'd0;
      if (sel == 1) begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
      if (sel == 2) r_b = $urandom_range(1, 20);
      if (sel == 4) r_a = 32'h8000_0000;
      run_op(r_op, r_a, r_b, 5'($urandom), (sel == 3) ? 2 : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
